// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Operation and state encodings shared by the multiply/divide
//               unit and its arithmetic core.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    // 3'd7 is reserved and behaves as OP_NOP

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide core. Produces {HI,LO} from the
//               latched operands plus a write-enable that is low for a
//               divide by zero (HI/LO must then stay unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_result,
    output logic        o_wr
);

    logic               w_b_nz;
    logic               w_ovf;
    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_bdiv_s;
    logic        [31:0] w_bdiv_u;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;

    assign w_b_nz = (i_b != 32'd0);
    // The only signed quotient that cannot be represented: -2^31 / -1
    assign w_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    assign w_a_sx   = {{32{i_a[31]}}, i_a};
    assign w_b_sx   = {{32{i_b[31]}}, i_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Substitute a divisor of 1 for the zero case (result discarded) and for
    // the overflow case, where dividing by 1 yields exactly the required
    // quotient 0x80000000 and remainder 0.
    assign w_a_s    = i_a;
    assign w_bdiv_s = (!w_b_nz || w_ovf) ? 32'sd1 : i_b;
    assign w_bdiv_u = w_b_nz ? i_b : 32'd1;

    // Signed / and % truncate toward zero; remainder takes the dividend's sign
    assign w_q_s = w_a_s / w_bdiv_s;
    assign w_r_s = w_a_s % w_bdiv_s;
    assign w_q_u = i_a / w_bdiv_u;
    assign w_r_u = i_a % w_bdiv_u;

    // Select the result for the latched operation
    always_comb begin
        o_result = 64'd0;
        o_wr     = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_result = w_prod_s;
                o_wr     = 1'b1;
            end
            OP_MULTU: begin
                o_result = w_prod_u;
                o_wr     = 1'b1;
            end
            OP_DIV: begin
                o_result = {w_r_s, w_q_s};
                o_wr     = w_b_nz;
            end
            OP_DIVU: begin
                o_result = {w_r_u, w_q_u};
                o_wr     = w_b_nz;
            end
            default: begin
                o_result = 64'd0;
                o_wr     = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : MIPS multiply/divide unit. Holds HI/LO, runs MULT/DIV ops for
//               a fixed number of cycles (busy high), and handles MTHI/MTLO
//               writes immediately. rd_data returns HI or LO combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [2:0]         r_op;
    logic               w_latch;
    logic [63:0]        w_result;
    logic               w_result_wr;

    mdu_arith u_arith (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_wr     (w_result_wr)
    );

    // Next-state, counter and HI/LO update logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_latch     = 1'b1;
                            w_cnt_nxt   = c_MULT_LOAD;
                            w_state_nxt = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_latch     = 1'b1;
                            w_cnt_nxt   = c_DIV_LOAD;
                            w_state_nxt = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = a;
                        OP_MTLO: w_lo_nxt = a;
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                // start is ignored here; the pipeline is stalled on busy
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    if (w_result_wr) begin
                        w_hi_nxt = w_result[63:32];
                        w_lo_nxt = w_result[31:0];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cycle counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    // Operand/op capture so later changes on a/b cannot affect the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_op <= OP_NOP;
        end else if (w_latch) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
        end
    end

    assign busy    = (r_state == S_RUN);
    assign rd_data = rd_sel ? r_hi : r_lo;
    assign hi_out  = r_hi;
    assign lo_out  = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd_sel  (rd_sel),
        .busy    (busy),
        .rd_data (rd_data),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the falling edge after the start edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NOP;
    endtask

    // Count falling edges with busy high, bounded
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_checks++; if (hi_out !== 32'd0)  begin n_fail++; $display("FAIL reset_hi got %h exp 0", hi_out); end
        n_checks++; if (lo_out !== 32'd0)  begin n_fail++; $display("FAIL reset_lo got %h exp 0", lo_out); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", rd_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        rd_sel = 1'b0;
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mult_old_rd got %h exp 0", rd_data); end
        wait_idle(cyc);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d exp 5", cyc); end
        n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h exp ffffffff", hi_out); end
        n_checks++; if (lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h exp fffffff1", lo_out); end
        n_checks++; if (rd_data !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_rd got %h exp fffffff1", rd_data); end
    endtask

    task automatic test_multu();
        int cyc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL multu_busy_cycles got %0d exp 5", cyc); end
        n_checks++; if (hi_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi got %h exp 00000001", hi_out); end
        n_checks++; if (lo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got %h exp fffffffe", lo_out); end
        rd_sel = 1'b0;
        #1;
        n_checks++; if (rd_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_rd_lo got %h exp fffffffe", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_checks++; if (rd_data !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_rd_hi got %h exp 00000001", rd_data); end
        rd_sel = 1'b0;
    endtask

    task automatic test_div();
        int cyc;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d exp 10", cyc); end
        n_checks++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h exp fffffffd", lo_out); end
        n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h exp ffffffff", hi_out); end
    endtask

    task automatic test_divu_zero();
        int cyc;
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        n_checks++; if (hi_out !== 32'h11) begin n_fail++; $display("FAIL mthi_preset got %h exp 00000011", hi_out); end
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL divz_busy_cycles got %0d exp 10", cyc); end
        n_checks++; if (hi_out !== 32'h11) begin n_fail++; $display("FAIL divz_hi got %h exp 00000011", hi_out); end
        n_checks++; if (lo_out !== 32'h22) begin n_fail++; $display("FAIL divz_lo got %h exp 00000022", lo_out); end
    endtask

    task automatic test_ignore_during_run();
        int cyc;
        issue(OP_MULT, 32'd3, 32'd4);
        // one cycle into RUN: attempt an MTHI then a new MULT
        op    = OP_MTHI;
        a     = 32'hDEAD;
        start = 1'b1;
        @(negedge clk);
        op    = OP_MULT;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NOP;
        a     = 32'd77;
        b     = 32'd88;
        n_checks++; if (hi_out !== 32'h11) begin n_fail++; $display("FAIL ignore_hi_midrun got %h exp 00000011", hi_out); end
        wait_idle(cyc);
        cyc = cyc + 2;
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d exp 5", cyc); end
        n_checks++; if (hi_out !== 32'd0)  begin n_fail++; $display("FAIL ignore_hi got %h exp 0", hi_out); end
        n_checks++; if (lo_out !== 32'd12) begin n_fail++; $display("FAIL ignore_lo got %h exp 0000000c", lo_out); end
    endtask

    task automatic test_mtlo_and_overflow();
        int cyc;
        issue(OP_MTLO, 32'h1234, 32'd0);
        n_checks++; if (lo_out !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo got %h exp 00001234", lo_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got %h exp 0", busy); end
        issue(OP_NOP + 3'd7, 32'hBEEF, 32'd1);
        n_checks++; if (busy !== 1'b0 || lo_out !== 32'h1234) begin n_fail++; $display("FAIL reserved_op busy %h lo %h exp 0 00001234", busy, lo_out); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL ovf_busy_cycles got %0d exp 10", cyc); end
        n_checks++; if (lo_out !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo got %h exp 80000000", lo_out); end
        n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL ovf_hi got %h exp 0", hi_out); end
        issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL divu_big_lo got %h exp 0", lo_out); end
        n_checks++; if (hi_out !== 32'h8000_0000) begin n_fail++; $display("FAIL divu_big_hi got %h exp 80000000", hi_out); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        issue(OP_MTLO, 32'h5555, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstrun_busy got %h exp 0", busy); end
        n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL rstrun_hi got %h exp 0", hi_out); end
        n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL rstrun_lo got %h exp 0", lo_out); end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || lo_out !== 32'd0) begin n_fail++; $display("FAIL rstrun_stale busy %h lo %h exp 0 0", busy, lo_out); end
        issue(OP_MULT, 32'd2, 32'd3);
        wait_idle(cyc);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL post_rst_busy_cycles got %0d exp 5", cyc); end
        n_checks++; if (lo_out !== 32'd6) begin n_fail++; $display("FAIL post_rst_lo got %h exp 00000006", lo_out); end
        n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi got %h exp 0", hi_out); end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = OP_NOP;
        a      = 32'd0;
        b      = 32'd0;
        rd_sel = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_ignore_during_run();
        test_mtlo_and_overflow();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit for the MIPS datapath, placed beside the ALU. Operand A comes from GRF rs; operand B comes from the ALU-source selector output. HI/LO results are returned through rd_data, which feeds one input of the register-write-data selector. Latency is multi-cycle and exposed through a busy flag; the control unit uses busy to stall.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1)
DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  qualifies op for one cycle
op  input  3  operation code (see package)
a  input  32  operand A (rs)
b  input  32  operand B (ALU-source selector output)
rd_sel  input  1  0 = read LO, 1 = read HI
busy  output  1  long operation in progress
rd_data  output  32  selected HI/LO, combinational
hi_out  output  32  HI register, debug/trace
lo_out  output  32  LO register, debug/trace

Behaviour:
- Reset (asynchronous, active-high): HI=0, LO=0, busy=0, counter=0, latched operands/op cleared. Deasserting reset starts normal operation on the next edge.
- States: IDLE, RUN.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch a, b, op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy is 1 from this edge.
  - start=1 with MTHI/MTLO: write a into HI/LO at this edge; no busy.
  - start=0, or op NOP/reserved: no change.
- RUN:
  - Counter decrements once per edge.
  - On the edge where the counter reaches 0: HI/LO take the result, busy drops to 0, return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. Results are visible on rd_data in the same cycle busy first reads 0.
  - Any start during RUN, including MTHI/MTLO, is ignored. The control unit guarantees a stall; the bench checks that the ignore rule holds.
- Result computed from latched operands only; a/b changes during RUN have no effect.
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (b=0, DIV or DIVU): full DIV_CYCLES busy, then HI/LO unchanged.
- rd_data = rd_sel ? HI : LO, combinational. During RUN it returns the old value.
- Reset mid-RUN: the pending result is discarded and the reset values apply immediately.

Decomposition:
- Shared package mdu_pkg holds the op encodings:
  - OP_NOP=3'd0
  - OP_MULT=3'd1
  - OP_MULTU=3'd2
  - OP_DIV=3'd3
  - OP_DIVU=3'd4
  - OP_MTHI=3'd5
  - OP_MTLO=3'd6
  - 3'd7 reserved, treated as NOP
- The package also holds the state encodings S_IDLE/S_RUN.
- One sub-module is natural: mdu_arith, combinational. It takes latched a, b, op and produces the 64-bit {hi,lo} result, including the divide-by-zero and overflow rules. The top level holds the FSM, counter and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start 1 cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. rd_sel toggle -> rd_data follows combinationally.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 with HI=0x11, LO=0x22 preset -> after 10 cycles HI/LO still 0x11/0x22.
- During RUN of MULT (3,4), pulse start with MTHI a=0xDEAD and MULT (9,9); also change a/b -> both ignored; final HI=0, LO=12.
- MTLO a=0x1234 in IDLE -> LO=0x1234 next edge, busy stays 0. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV, assert reset asynchronously at cycle 4 (between edges) -> busy, HI, LO go to 0 immediately. After release, a new MULT 2*3 completes normally with LO=6.
